// File: rtl/cus42_tile_fetch.sv
// cus42_tile_fetch: pixel/line counters, double-buffered scroll registers and the
// tilemap / gfx-ROM address generator that feeds the cus43 dual tilemap generator.
module cus42_tile_fetch #(
    parameter int HTOTAL = 384,
    parameter int VTOTAL = 264
) (
    input  logic        CLK_6M,
    input  logic        RST,
    input  logic        LINE_START,
    input  logic        FRAME_START,
    input  logic        CS,
    input  logic        nWE,
    input  logic [2:0]  CA,
    input  logic [7:0]  CD,
    input  logic        FLIP,
    output logic [11:0] MA,
    input  logic [15:0] MD,
    output logic [14:0] GA,
    output logic [7:0]  ATTR,
    output logic        CLK_2H,
    output logic        HA2,
    output logic        HB2
);
    localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);

    logic [8:0]  r_hcnt;
    logic [8:0]  r_vcnt;
    logic [8:0]  w_hcnt_nxt;
    logic [8:0]  w_vcnt_nxt;
    logic        w_line_end;
    logic        w_cpu_wr;

    logic [8:0]  r_scrx_a_sh;
    logic [8:0]  r_scrx_b_sh;
    logic [8:0]  r_scrx_a_act;
    logic [8:0]  r_scrx_b_act;
    logic [7:0]  r_scry_a_sh;
    logic [7:0]  r_scry_b_sh;
    logic [7:0]  r_scry_a_act;
    logic [7:0]  r_scry_b_act;

    // Tile record layout: {attr[7:0], code[7:0], fine_row[2:0]}
    logic [18:0] r_next_a;
    logic [18:0] r_next_b;
    logic [18:0] r_cur_a;
    logic [18:0] r_cur_b;
    logic [18:0] w_cur_a_nxt;
    logic [18:0] w_cur_b_nxt;
    logic [18:0] w_tile_sel;

    logic [2:0]  r_fine_pend;
    logic [2:0]  w_ph_nxt;
    logic [2:0]  w_fine_nxt;
    logic [5:0]  w_slot_nxt;
    logic [5:0]  w_scx_sel;
    logic [5:0]  w_col;
    logic [7:0]  w_scy_sel;
    logic [7:0]  w_row;
    logic        w_sel_b;
    logic        w_half;
    logic [11:0] w_ma_nxt;
    logic [11:0] w_unused_fine_x;

    // Fine X scroll is kept for CPU compatibility only; X scrolling is tile-granular.
    assign w_unused_fine_x = {r_scrx_a_sh[2:0], r_scrx_b_sh[2:0],
                              r_scrx_a_act[2:0], r_scrx_b_act[2:0]};
    assign w_cpu_wr = CS & ~nWE;

    function automatic logic [5:0] f_col(input logic [5:0] slot,
                                         input logic [5:0] scx,
                                         input logic       flip);
        logic [5:0] j;
        j = flip ? ~(slot + 6'd1) : (slot + 6'd1);
        return j + scx;
    endfunction

    // Counter next-state: LINE_START and the natural wrap share a single vcnt step.
    always_comb begin
        w_line_end = (r_hcnt == H_LAST);
        if (LINE_START || w_line_end) begin
            w_hcnt_nxt = 9'd0;
        end else begin
            w_hcnt_nxt = r_hcnt + 9'd1;
        end
        if (FRAME_START) begin
            w_vcnt_nxt = 9'd0;
        end else if (LINE_START || w_line_end) begin
            w_vcnt_nxt = (r_vcnt == V_LAST) ? 9'd0 : r_vcnt + 9'd1;
        end else begin
            w_vcnt_nxt = r_vcnt;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK_6M) begin
        if (RST) begin
            r_hcnt <= 9'd0;
            r_vcnt <= 9'd0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
        end
    end

    // Shadow scroll writes and frame-synchronous copy to the active set.
    always_ff @(posedge CLK_6M) begin
        if (RST) begin
            r_scrx_a_sh  <= 9'd0;
            r_scrx_b_sh  <= 9'd0;
            r_scry_a_sh  <= 8'd0;
            r_scry_b_sh  <= 8'd0;
            r_scrx_a_act <= 9'd0;
            r_scrx_b_act <= 9'd0;
            r_scry_a_act <= 8'd0;
            r_scry_b_act <= 8'd0;
        end else begin
            if (FRAME_START) begin
                r_scrx_a_act <= r_scrx_a_sh;
                r_scrx_b_act <= r_scrx_b_sh;
                r_scry_a_act <= r_scry_a_sh;
                r_scry_b_act <= r_scry_b_sh;
            end
            if (w_cpu_wr) begin
                case (CA)
                    3'd0:    r_scrx_a_sh[8]   <= CD[0];
                    3'd1:    r_scrx_a_sh[7:0] <= CD;
                    3'd2:    r_scry_a_sh      <= CD;
                    3'd4:    r_scrx_b_sh[8]   <= CD[0];
                    3'd5:    r_scrx_b_sh[7:0] <= CD;
                    3'd6:    r_scry_b_sh      <= CD;
                    default: ;
                endcase
            end
        end
    end

    // Address for the phase about to start; scroll values are those active during it.
    always_comb begin
        w_ph_nxt   = w_hcnt_nxt[2:0];
        w_slot_nxt = w_hcnt_nxt[8:3];
        w_sel_b    = w_ph_nxt[1];
        if (w_sel_b) begin
            w_scx_sel = FRAME_START ? r_scrx_b_sh[8:3] : r_scrx_b_act[8:3];
            w_scy_sel = FRAME_START ? r_scry_b_sh : r_scry_b_act;
        end else begin
            w_scx_sel = FRAME_START ? r_scrx_a_sh[8:3] : r_scrx_a_act[8:3];
            w_scy_sel = FRAME_START ? r_scry_a_sh : r_scry_a_act;
        end
        w_row      = w_vcnt_nxt[7:0] + w_scy_sel;
        w_col      = f_col(w_slot_nxt, w_scx_sel, FLIP);
        w_fine_nxt = w_row[2:0] ^ {3{FLIP}};
        case (w_ph_nxt)
            3'd4:    w_ma_nxt = {1'b0, w_row[7:3], w_col};
            3'd6:    w_ma_nxt = {1'b1, w_row[7:3], w_col};
            default: w_ma_nxt = 12'd0;
        endcase
    end

    // The tile pair swaps in on the edge ending p7, so p0 output already sees it.
    always_comb begin
        w_cur_a_nxt = (r_hcnt[2:0] == 3'd7) ? r_next_a : r_cur_a;
        w_cur_b_nxt = (r_hcnt[2:0] == 3'd7) ? r_next_b : r_cur_b;
        w_tile_sel  = w_sel_b ? w_cur_b_nxt : w_cur_a_nxt;
        w_half      = w_ph_nxt[2] ^ FLIP;
    end

    // Tile capture pipeline: MD sampled at the end of p4 (A) and p6 (B).
    always_ff @(posedge CLK_6M) begin
        if (RST) begin
            r_fine_pend <= 3'd0;
            r_next_a    <= 19'd0;
            r_next_b    <= 19'd0;
            r_cur_a     <= 19'd0;
            r_cur_b     <= 19'd0;
        end else begin
            if ((w_ph_nxt == 3'd4) || (w_ph_nxt == 3'd6)) begin
                r_fine_pend <= w_fine_nxt;
            end
            if (r_hcnt[2:0] == 3'd4) begin
                r_next_a <= {MD, r_fine_pend};
            end
            if (r_hcnt[2:0] == 3'd6) begin
                r_next_b <= {MD, r_fine_pend};
            end
            r_cur_a <= w_cur_a_nxt;
            r_cur_b <= w_cur_b_nxt;
        end
    end

    // Registered outputs, updated on the edge that opens each window.
    always_ff @(posedge CLK_6M) begin
        if (RST) begin
            MA     <= 12'd0;
            GA     <= 15'd0;
            ATTR   <= 8'd0;
            CLK_2H <= 1'b0;
            HA2    <= 1'b0;
            HB2    <= 1'b0;
        end else begin
            MA     <= w_ma_nxt;
            GA     <= {w_tile_sel[13:0], w_half};
            ATTR   <= w_tile_sel[18:11];
            CLK_2H <= w_ph_nxt[1];
            HA2    <= (w_ph_nxt == 3'd1);
            HB2    <= (w_ph_nxt == 3'd1);
        end
    end

endmodule

// File: tb/tb_cus42_tile_fetch.sv
// Directed bench for cus42_tile_fetch: reset, fetch addressing, shadow scroll,
// counter wrap, screen flip and write/FRAME_START collision.
module tb_cus42_tile_fetch;
    logic        clk;
    logic        rst;
    logic        line_start;
    logic        frame_start;
    logic        cs;
    logic        nwe;
    logic [2:0]  ca;
    logic [7:0]  cd;
    logic        flip;
    logic [11:0] ma;
    logic [15:0] md;
    logic [14:0] ga;
    logic [7:0]  attr;
    logic        clk_2h;
    logic        ha2;
    logic        hb2;

    int n_tests = 0;
    int n_fail  = 0;
    int h = 0;
    int v = 0;

    cus42_tile_fetch #(.HTOTAL(384), .VTOTAL(264)) dut (
        .CLK_6M(clk), .RST(rst), .LINE_START(line_start), .FRAME_START(frame_start),
        .CS(cs), .nWE(nwe), .CA(ca), .CD(cd), .FLIP(flip),
        .MA(ma), .MD(md), .GA(ga), .ATTR(attr),
        .CLK_2H(clk_2h), .HA2(ha2), .HB2(hb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (h=%0d v=%0d)", tag, got, exp, h, v);
        end
    endtask

    // One clock; tracks the expected raster position from the applied inputs.
    task automatic step();
        int nv;
        @(posedge clk);
        if (rst) begin
            h = 0;
            v = 0;
        end else begin
            if (frame_start) nv = 0;
            else if (line_start || h == 383) nv = (v == 263) ? 0 : v + 1;
            else nv = v;
            if (line_start || h == 383) h = 0;
            else h = h + 1;
            v = nv;
        end
        #1;
    endtask

    task automatic goto(input int slot, input int ph);
        int n;
        n = 0;
        while (h != slot * 8 + ph && n < 800) begin
            step();
            n++;
        end
        if (n >= 800) begin
            n_fail++;
            $display("FAIL goto: position %0d/%0d not reached", slot, ph);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; nwe = 1'b0; ca = a; cd = d;
        step();
        cs = 1'b0; nwe = 1'b1;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1; line_start = 1'b1;
        step();
        frame_start = 1'b0; line_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; line_start = 1'b0; frame_start = 1'b0;
        cs = 1'b0; nwe = 1'b1; ca = 3'd0; cd = 8'd0; flip = 1'b0; md = 16'h1234;
        step(); step();
        rst = 1'b0;
        repeat (50) step();

        // Reset mid-line
        rst = 1'b1;
        repeat (3) step();
        check_eq("rst_ma", 32'(ma), 32'h0);
        check_eq("rst_ga", 32'(ga), 32'h0);
        check_eq("rst_attr", 32'(attr), 32'h0);
        check_eq("rst_clk2h", 32'(clk_2h), 32'h0);
        check_eq("rst_ha2", 32'(ha2), 32'h0);
        check_eq("rst_hb2", 32'(hb2), 32'h0);
        rst = 1'b0;
        for (int i = 1; i < 12; i++) begin
            step();
            check_eq("pat_clk2h", 32'(clk_2h), 32'((i >> 1) & 1));
            check_eq("pat_ha2", 32'(ha2), 32'((i % 8) == 1));
            check_eq("pat_hb2", 32'(hb2), 32'((i % 8) == 1));
        end

        // Fetch / address
        cpu_wr(3'd0, 8'h00);
        cpu_wr(3'd1, 8'h10);
        cpu_wr(3'd2, 8'h05);
        frame_pulse();
        goto(0, 4);
        check_eq("fetch_ma_a", 32'(ma), 32'h003);
        step();
        check_eq("fetch_ma_p5", 32'(ma), 32'h000);
        goto(0, 6);
        check_eq("fetch_ma_b", 32'(ma), 32'h801);
        goto(1, 0);
        check_eq("fetch_ga_p0", 32'(ga), 32'h234A);
        check_eq("fetch_attr", 32'(attr), 32'h12);
        step();
        check_eq("fetch_ga_p1", 32'(ga), 32'h234A);
        check_eq("fetch_ha2_p1", 32'(ha2), 32'h1);
        check_eq("fetch_hb2_p1", 32'(hb2), 32'h1);
        goto(1, 2);
        check_eq("fetch_ga_b", 32'(ga), 32'h2340);
        check_eq("fetch_clk2h_b", 32'(clk_2h), 32'h1);
        goto(1, 4);
        check_eq("fetch_ga_h1", 32'(ga), 32'h234B);
        check_eq("fetch_ma_s1", 32'(ma), 32'h004);

        // Shadow: SCRY_B write only takes effect after FRAME_START
        cpu_wr(3'd6, 8'h40);
        goto(1, 6);
        check_eq("shadow_before", 32'(ma), 32'h802);
        frame_pulse();
        goto(0, 6);
        check_eq("shadow_after", 32'(ma), 32'hA01);

        // Wrap: coarse X wraps to column 0; one vcnt step per line end
        cpu_wr(3'd0, 8'h01);
        cpu_wr(3'd1, 8'hF8);
        cpu_wr(3'd2, 8'h45);
        frame_pulse();
        goto(0, 4);
        check_eq("wrap_ma_col0", 32'(ma), 32'h200);
        goto(47, 7);
        goto(1, 0);
        check_eq("wrap_nat_fine", 32'(ga), 32'h234C);
        goto(47, 7);
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        goto(0, 4);
        check_eq("wrap_ls_ma", 32'(ma), 32'h200);
        goto(1, 0);
        check_eq("wrap_ls_fine", 32'(ga), 32'h234E);

        // Flip
        flip = 1'b1;
        cpu_wr(3'd0, 8'h00);
        cpu_wr(3'd1, 8'h10);
        cpu_wr(3'd2, 8'h05);
        frame_pulse();
        goto(0, 4);
        check_eq("flip_ma_s0", 32'(ma), 32'h000);
        goto(1, 0);
        check_eq("flip_ga_p0", 32'(ga), 32'h2345);
        step();
        check_eq("flip_ga_p1", 32'(ga), 32'h2345);
        goto(1, 4);
        check_eq("flip_ga_p4", 32'(ga), 32'h2344);
        check_eq("flip_ma_s1", 32'(ma), 32'h03F);
        goto(1, 6);
        check_eq("flip_ma_b", 32'(ma), 32'hA3D);
        flip = 1'b0;

        // Write colliding with FRAME_START
        cs = 1'b1; nwe = 1'b0; ca = 3'd2; cd = 8'h80;
        frame_start = 1'b1; line_start = 1'b1;
        step();
        cs = 1'b0; nwe = 1'b1; frame_start = 1'b0; line_start = 1'b0;
        goto(0, 4);
        check_eq("coll_ma_old", 32'(ma), 32'h003);
        goto(1, 0);
        check_eq("coll_ga_old", 32'(ga), 32'h234A);
        frame_pulse();
        goto(0, 4);
        check_eq("coll_ma_new", 32'(ma), 32'h403);
        goto(1, 0);
        check_eq("coll_ga_new", 32'(ga), 32'h2340);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cus42_tile_fetch.md
Name: cus42_tile_fetch

Overview:
- Dual-layer scroll and address generator, directly upstream of the cus43 dual tilemap generator.
- Runs the horizontal/vertical pixel counters and holds the CPU-written scroll registers.
- Reads tile words from tilemap RAM, drives graphics ROM row addresses and attribute bytes, and drives the CLK_2H/HA2/HB2 strobes. These strobes let cus43 latch 4-pixel plane nibbles and load its 8-pixel shifters.

Parameters:
- HTOTAL, 384, pixel clocks per line (multiple of 8).
- VTOTAL, 264, lines per frame.

Ports:
- CLK_6M  in  1  pixel clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- LINE_START  in  1  one-cycle pulse; forces hcnt to 0 next cycle.
- FRAME_START  in  1  one-cycle pulse; forces vcnt to 0 and copies shadow scroll registers to active.
- CS  in  1  CPU register select.
- nWE  in  1  CPU write strobe, active-low.
- CA  in  3  CPU register address.
- CD  in  8  CPU write data.
- FLIP  in  1  screen flip.
- MA  out  12  tilemap RAM word address {layer, row[4:0], col[5:0]}.
- MD  in  16  tilemap RAM data {attr[7:0], code[7:0]}; valid in the same cycle MA is driven.
- GA  out  15  gfx ROM address {attr[2:0], code[7:0], fine_row[2:0], half}.
- ATTR  out  8  attribute byte of the layer currently in its window (feeds cus43 MDI).
- CLK_2H  out  1  layer select, = hcnt[1] (0 = layer A, 1 = layer B).
- HA2  out  1  layer A shifter load strobe.
- HB2  out  1  layer B shifter load strobe.

Behaviour:
Counters
- hcnt (9b): +1 per clock; wraps HTOTAL-1 -> 0. LINE_START forces 0 next cycle.
- vcnt (9b): +1 on each hcnt wrap or LINE_START; wraps VTOTAL-1 -> 0. FRAME_START forces 0.
- LINE_START coinciding with a natural wrap gives one vcnt increment only.

Slot timing
- Slot k = hcnt[8:3]; phase p = hcnt[2:0].

Scroll registers
- Written on a clock edge when CS=1 and nWE=0:
  - CA0: SCRX_A[8] = CD[0]
  - CA1: SCRX_A[7:0]
  - CA2: SCRY_A
  - CA4/5/6: same for layer B
  - CA3/CA7: ignored
- Writes go to the shadow registers. Active registers take the shadow values on FRAME_START.
- Write coinciding with FRAME_START: active takes the pre-write shadow value; the write lands in shadow.
- Fine X scroll (SCRX[2:0]) is stored but unused; scrolling is tile-granular in X.

Address arithmetic (mod widths)
- r = (vcnt[7:0] + SCRY) mod 256.
- col(j) = (j + SCRX[8:3]) mod 64.
- FLIP=1: column index j replaced by ~j (6b); fine_row = r[2:0] ^ 7; half inverted.

Fetch
- p4: MA = {0, r_A[7:3], col_A(k+1)}; MD registered at end of p4 into nextA, together with fine_row_A.
- p6: same for layer B (layer bit 1) into nextB.
- End of p7: nextA -> curA, nextB -> curB.
- MA = 0 on all other phases.

Output windows
- GA and ATTR are registered and change on the rising edge that starts each window:
  - p0-1: layer A, half 0
  - p2-3: layer B, half 0
  - p4-5: layer A, half 1
  - p6-7: layer B, half 1
- GA = {cur.attr[2:0], cur.code, cur.fine_row, half}; ATTR = cur.attr.
- HA2 = HB2 = 1 during p1 only, so cus43 loads both shifters on the edge ending p1.
- Tile latency: a tile fetched in slot k is driven in slot k+1 and displayed from slot k+1 p2.

Reset
- RST=1 clears: hcnt, vcnt, shadow/active scroll, cur/next tiles, MA, GA, ATTR, CLK_2H, HA2, HB2 (all 0).
- Reset mid-slot abandons the fetch in progress; no strobes while RST=1.

Test Plan:
- Reset: RST high 3 cycles mid-line -> all outputs 0; after release hcnt=0, HA2/HB2 first high in the 2nd cycle (p1); CLK_2H pattern 0,0,1,1 repeating.
- Fetch/address: write CA0=0, CA1=0x10, CA2=0x05, pulse FRAME_START, MD=0x1234 at vcnt=0 slot 0 p4 -> MA=0x003; slot 1 p0-1 GA=0x234A, ATTR=0x12; p4-5 GA=0x234B.
- Shadow: write CA6=0x40 mid-frame -> layer B MA row field unchanged until after next FRAME_START, then row = (vcnt+0x40)[7:3].
- Wrap: SCRX_A=0x1F8 -> slot 0 p4 MA col=0; hcnt 383 -> 0 increments vcnt once; LINE_START at hcnt=383 also increments vcnt once.
- FLIP=1 with the fetch/address scroll setup -> col=(~1+2) mod 64=0 at slot 0; GA fine_row=2, half=1 in p0-1.
- Simultaneous: CPU write to CA2 in the same cycle as FRAME_START -> active SCRY_A keeps the old shadow value; new value becomes active at the following FRAME_START.
